uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer placed between the UART receive engine and the TramelBlaze I/O bus. Each byte the receive engine flags ready is captured together with its error flags into a DEPTH-entry FIFO, and the engine is acknowledged with a one-cycle clear pulse. The processor pops bytes through a data port, reads a status port, and gets a level interrupt while the FIFO is non-empty. This makes the processor tolerant of receive bursts longer than one character time.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- DATA_PORT, 16'h0000, port_id that pops and returns data
- STAT_PORT, 16'h0001, port_id that returns status; a write to it clears sticky overflow
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rx_rdy  in  1  receive engine byte-ready level
- rx_data  in  8  receive engine data
- ferr, perr, ovf  in  1 each  receive engine error flags, valid with rx_rdy
- rx_clr  out  1  one-cycle acknowledge pulse to the receive engine
- port_id  in  16  processor port address
- read_strobe  in  1  processor read strobe, one cycle
- write_strobe  in  1  processor write strobe, one cycle
- out_port  in  16  processor write data (ignored; a write only triggers the clear)
- in_port  out  16  processor read data
- rx_int  out  1  interrupt request, registered

## Operation
- Entry = {ovf, perr, ferr, rx_data}, 11 bits. Storage is DEPTH x 11.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Capture FSM:
  - IDLE: if rx_rdy, push (if not full), go to ACK.
  - ACK: rx_clr = 1, go to WAIT.
  - WAIT: stay until rx_rdy = 0, then go to IDLE.
  - This prevents double capture if rx_rdy falls late.
- Push when full (checked before any same-cycle pop):
  - Byte is dropped and sticky fovf is set.
  - rx_clr is still issued.
  - Exception: if a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Pop: read_strobe & port_id==DATA_PORT & not empty advances the read pointer. Pop when empty is ignored.
- in_port, combinational on port_id:
  - DATA_PORT: {8'h00, head data}, or 16'h0000 when empty.
  - STAT_PORT: bits as follows.
    - [0] not-empty
    - [1] full
    - [2] fovf
    - [3] head ferr
    - [4] head perr
    - [5] head ovf
    - [7:6] 0
    - [12:8] count
    - [15:13] 0
  - Head error bits are 0 when empty.
  - Any other port_id: 16'h0000.
- write_strobe & port_id==STAT_PORT clears fovf. If an overflow occurs in the same cycle, set wins.
- Simultaneous push and pop: both take effect, count unchanged, data ordering preserved.
- rx_int is registered (count != 0).

## Timing
- Reset values: rx_clr 0, rx_int 0, pointers 0, count 0, fovf 0, state IDLE. in_port then reads 16'h0000 on DATA_PORT and 16'h0000 on STAT_PORT.
- rx_rdy sampled high at edge n:
  - Entry written and count updated at edge n.
  - rx_clr high for cycle n..n+1.
  - rx_int rises one edge after count becomes non-zero.
- Pop at edge m: the new head is visible on in_port in the cycle after m. rx_int falls one edge after count reaches 0.
- Reset asserted mid-operation: all state is cleared immediately, rx_clr drops asynchronously, and FIFO contents are discarded (the storage array need not be reset).
- Minimum spacing between captures is 3 cycles: IDLE, ACK, WAIT.

## Structure
- Shared package (uart_pkg): port-address constants, status bit indices, entry field offsets.
- One sub-module, uart_fifo_mem: parameterised DEPTH x WIDTH register file with synchronous write and asynchronous read.
- The FSM, pointers, flags and port mux live in uart_rx_fifo.

## Test plan
- Reset then idle:
  - STAT_PORT reads 16'h0000.
  - rx_int = 0, rx_clr = 0.
- Single byte 8'hA5 with ferr=1:
  - rx_clr is exactly one cycle.
  - STAT reads 16'h0109.
  - DATA reads 16'h00A5; the pop empties the FIFO and rx_int falls.
- Ten bytes 8'h01..8'h0A with DEPTH=8:
  - STAT reads 16'h0807.
  - Eight pops return 01..08 in order.
  - A write to STAT_PORT then gives STAT 16'h0000.
- Push and pop in the same cycle with count=3: count stays 3 and the FIFO order is intact.
- Pointer wrap: 20 push/pop pairs at count 1..2, all data matches.
- rx_rdy held high for 10 cycles after rx_clr: only one entry is captured.
- reset pulsed low during ACK: rx_clr drops immediately and count = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: port addresses, status bits,
// entry field offsets and the capture FSM state type.
package uart_pkg;
  localparam logic [15:0] DATA_PORT_DEF = 16'h0000;
  localparam logic [15:0] STAT_PORT_DEF = 16'h0001;

  localparam int ENTRY_W    = 11;
  localparam int E_DATA_LSB = 0;
  localparam int E_FERR     = 8;
  localparam int E_PERR     = 9;
  localparam int E_OVF      = 10;

  localparam int S_NEMPTY  = 0;
  localparam int S_FULL    = 1;
  localparam int S_FOVF    = 2;
  localparam int S_FERR    = 3;
  localparam int S_PERR    = 4;
  localparam int S_OVF     = 5;
  localparam int S_CNT_LSB = 8;
  localparam int S_CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } cap_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-engine handshake plus TramelBlaze I/O bus signals for the RX buffer.
interface uart_rx_fifo_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        ferr;
  logic        perr;
  logic        ovf;
  logic        rx_clr;
  logic [15:0] port_id;
  logic        read_strobe;
  logic        write_strobe;
  logic [15:0] out_port;
  logic [15:0] in_port;
  logic        rx_int;

  modport master (
    output rx_rdy, rx_data, ferr, perr, ovf, port_id, read_strobe, write_strobe, out_port,
    input  rx_clr, in_port, rx_int
  );

  modport slave (
    input  rx_rdy, rx_data, ferr, perr, ovf, port_id, read_strobe, write_strobe, out_port,
    output rx_clr, in_port, rx_int
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module uart_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures engine bytes with error flags into a FIFO and
// serves them to the processor through a data port and a status port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DATA_PORT = DATA_PORT_DEF,
  parameter logic [15:0] STAT_PORT = STAT_PORT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cap_state_t           state, state_nxt;
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic                 fovf;
  logic                 rx_int_q;
  logic                 push_req, wr_en, pop, full, empty, ovf_set, fovf_clr;
  logic [ENTRY_W-1:0]   wr_entry, head;
  logic [15:0]          stat_word;
  logic                 unused_out_port;

  assign unused_out_port = ^bus.out_port;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture FSM: one push per rx_rdy assertion, then wait for the level to drop.
  always_comb begin
    state_nxt  = state;
    push_req   = 1'b0;
    bus.rx_clr = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.rx_rdy) begin
        push_req  = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        bus.rx_clr = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: if (!bus.rx_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = bus.read_strobe && (bus.port_id == DATA_PORT) && !empty;
  // A full FIFO still accepts the byte when a pop frees a slot in the same cycle.
  assign wr_en    = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign fovf_clr = bus.write_strobe && (bus.port_id == STAT_PORT);
  assign wr_entry = {bus.ovf, bus.perr, bus.ferr, bus.rx_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fovf     <= 1'b0;
      rx_int_q <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      if (ovf_set)       fovf <= 1'b1;
      else if (fovf_clr) fovf <= 1'b0;
      rx_int_q <= (count != '0);
    end
  end

  assign bus.rx_int = rx_int_q;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr),
    .rdata (head)
  );

  always_comb begin
    stat_word                           = '0;
    stat_word[S_NEMPTY]                 = !empty;
    stat_word[S_FULL]                   = full;
    stat_word[S_FOVF]                   = fovf;
    stat_word[S_FERR]                   = !empty && head[E_FERR];
    stat_word[S_PERR]                   = !empty && head[E_PERR];
    stat_word[S_OVF]                    = !empty && head[E_OVF];
    stat_word[S_CNT_LSB +: S_CNT_W]     = S_CNT_W'(count);
  end

  always_comb begin
    bus.in_port = 16'h0000;
    if (bus.port_id == DATA_PORT) begin
      if (!empty) bus.in_port = {8'h00, head[E_DATA_LSB +: 8]};
    end else if (bus.port_id == STAT_PORT) begin
      bus.in_port = stat_word;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=8): capture handshake, FIFO order,
// overflow, simultaneous push/pop, pointer wrap and asynchronous reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] p, output logic [15:0] v);
    bus.port_id = p;
    #1;
    v = bus.in_port;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic f, input logic p, input logic o);
    bus.rx_data = d;
    bus.ferr    = f;
    bus.perr    = p;
    bus.ovf     = o;
    bus.rx_rdy  = 1'b1;
    tick();
    bus.rx_rdy  = 1'b0;
    bus.ferr    = 1'b0;
    bus.perr    = 1'b0;
    bus.ovf     = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    bus.port_id     = DATA_PORT_DEF;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_stat got %h want 0000", v); end
    rd(DATA_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", v); end
    checks++; if (bus.rx_int !== 1'b0) begin errors++; $display("FAIL reset_rx_int got %b want 0", bus.rx_int); end
    checks++; if (bus.rx_clr !== 1'b0) begin errors++; $display("FAIL reset_rx_clr got %b want 0", bus.rx_clr); end
  endtask

  task automatic test_single();
    logic [15:0] v;
    bus.rx_data = 8'hA5;
    bus.ferr    = 1'b1;
    bus.rx_rdy  = 1'b1;
    tick();
    checks++; if (bus.rx_clr !== 1'b1) begin errors++; $display("FAIL single_clr_hi got %b want 1", bus.rx_clr); end
    bus.rx_rdy = 1'b0;
    bus.ferr   = 1'b0;
    tick();
    checks++; if (bus.rx_clr !== 1'b0) begin errors++; $display("FAIL single_clr_lo got %b want 0", bus.rx_clr); end
    tick();
    checks++; if (bus.rx_int !== 1'b1) begin errors++; $display("FAIL single_int_hi got %b want 1", bus.rx_int); end
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0109) begin errors++; $display("FAIL single_stat got %h want 0109", v); end
    rd(DATA_PORT_DEF, v);
    checks++; if (v !== 16'h00A5) begin errors++; $display("FAIL single_data got %h want 00a5", v); end
    pop();
    checks++; if (bus.rx_int !== 1'b1) begin errors++; $display("FAIL single_int_lag got %b want 1", bus.rx_int); end
    tick();
    checks++; if (bus.rx_int !== 1'b0) begin errors++; $display("FAIL single_int_lo got %b want 0", bus.rx_int); end
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL single_stat_empty got %h want 0000", v); end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    for (int i = 1; i <= 10; i++) push_byte(8'(i), 1'b0, 1'b0, 1'b0);
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0807) begin errors++; $display("FAIL ovf_stat got %h want 0807", v); end
    for (int i = 1; i <= 8; i++) begin
      rd(DATA_PORT_DEF, v);
      checks++; if (v !== 16'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, v, 16'(i)); end
      pop();
    end
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL ovf_sticky got %h want 0004", v); end
    bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ovf_clear got %h want 0000", v); end
  endtask

  task automatic test_push_pop_same();
    logic [15:0] v;
    logic [7:0]  exp [3];
    exp = '{8'h22, 8'h33, 8'h44};
    push_byte(8'h11, 1'b0, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0, 1'b0);
    push_byte(8'h33, 1'b0, 1'b0, 1'b0);
    bus.rx_data = 8'h44;
    bus.rx_rdy  = 1'b1;
    rd(DATA_PORT_DEF, v);
    checks++; if (v !== 16'h0011) begin errors++; $display("FAIL same_head got %h want 0011", v); end
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    bus.rx_rdy      = 1'b0;
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0301) begin errors++; $display("FAIL same_stat got %h want 0301", v); end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      rd(DATA_PORT_DEF, v);
      checks++; if (v !== {8'h00, exp[i]}) begin errors++; $display("FAIL same_order%0d got %h want %h", i, v, {8'h00, exp[i]}); end
      pop();
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] v;
    for (int i = 1; i <= 8; i++) push_byte(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    bus.rx_data     = 8'h99;
    bus.rx_rdy      = 1'b1;
    bus.port_id     = DATA_PORT_DEF;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    bus.rx_rdy      = 1'b0;
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0803) begin errors++; $display("FAIL fullpp_stat got %h want 0803", v); end
    tick();
    tick();
    for (int i = 2; i <= 9; i++) begin
      rd(DATA_PORT_DEF, v);
      if (i == 9) begin
        checks++; if (v !== 16'h0099) begin errors++; $display("FAIL fullpp_last got %h want 0099", v); end
      end else begin
        checks++; if (v !== 16'h0080 + 16'(i)) begin errors++; $display("FAIL fullpp_pop%0d got %h want %h", i, v, 16'h0080 + 16'(i)); end
      end
      pop();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    push_byte(8'h40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
      rd(DATA_PORT_DEF, v);
      checks++; if (v !== 16'h0040 + 16'(i)) begin errors++; $display("FAIL wrap%0d got %h want %h", i, v, 16'h0040 + 16'(i)); end
      pop();
    end
    rd(DATA_PORT_DEF, v);
    checks++; if (v !== 16'h0054) begin errors++; $display("FAIL wrap_last got %h want 0054", v); end
    pop();
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL wrap_empty got %h want 0000", v); end
  endtask

  task automatic test_hold_rdy();
    logic [15:0] v;
    bus.rx_data = 8'h5A;
    bus.perr    = 1'b1;
    bus.rx_rdy  = 1'b1;
    tick();
    repeat (11) tick();
    checks++; if (bus.rx_clr !== 1'b0) begin errors++; $display("FAIL hold_clr got %b want 0", bus.rx_clr); end
    bus.rx_rdy = 1'b0;
    bus.perr   = 1'b0;
    tick();
    tick();
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0111) begin errors++; $display("FAIL hold_stat got %h want 0111", v); end
    pop();
  endtask

  task automatic test_reset_ack();
    logic [15:0] v;
    bus.rx_data = 8'h77;
    bus.rx_rdy  = 1'b1;
    tick();
    checks++; if (bus.rx_clr !== 1'b1) begin errors++; $display("FAIL rack_clr_hi got %b want 1", bus.rx_clr); end
    reset = 1'b0;
    #1;
    checks++; if (bus.rx_clr !== 1'b0) begin errors++; $display("FAIL rack_clr_async got %b want 0", bus.rx_clr); end
    rd(STAT_PORT_DEF, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rack_stat got %h want 0000", v); end
    bus.rx_rdy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.rx_int !== 1'b0) begin errors++; $display("FAIL rack_int got %b want 0", bus.rx_int); end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    bus.rx_rdy       = 1'b0;
    bus.rx_data      = 8'h00;
    bus.ferr         = 1'b0;
    bus.perr         = 1'b0;
    bus.ovf          = 1'b0;
    bus.port_id      = 16'h0000;
    bus.read_strobe  = 1'b0;
    bus.write_strobe = 1'b0;
    bus.out_port     = 16'h0000;
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_same();
    test_full_push_pop();
    test_wrap();
    test_hold_rdy();
    test_reset_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
